// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, constants and helpers for the
// 4x4 keypad scan controller. The optional key queue is enabled with
// the KEYPAD_FIFO_EN macro.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    localparam logic [3:0] ROW_INIT = 4'b1110;
    localparam int         KEY_W    = 4;

    // Index of the lowest low bit in an active-low vector (3 if only bit 3 is low).
    function automatic logic [1:0] col_to_idx(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous key queue with push/pop, empty flag and a
// one-cycle drop pulse when a push finds the queue full with no pop.
// Only compiled and used when KEYPAD_FIFO_EN is defined.
`ifdef KEYPAD_FIFO_EN
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; a push into a full queue survives only alongside a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= push && !do_push;
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule
`endif

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: walking-0 row scan of a 4x4 keypad with press and
// release debouncing and a valid/ack key handoff. The scan freezes on a
// candidate key until it is either rejected or released.
// Define KEYPAD_FIFO_EN to queue keys in key_fifo instead of a single register.
module keypad_scan_controller
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       col_in,
    input  logic             key_ack,
    output logic [3:0]       row_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             key_ovf
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0]  DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || FIFO_DEPTH < 1) begin : g_bad_params
        $error("keypad_scan_controller: illegal parameter value");
    end

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [DIV_W-1:0]  dwell_cnt;
    logic [DIV_W-1:0]  dwell_nxt;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_nxt;
    logic [3:0]        row_q;
    logic [3:0]        row_nxt;
    logic [1:0]        col_idx;
    logic [1:0]        col_idx_nxt;
    logic              accept;
    logic [KEY_W-1:0]  new_code;

    assign row_out  = row_q;
    assign key_held = (state == HELD);
    assign new_code = {col_to_idx(row_q), col_idx};

    // Scan state, dwell/stability counters, row strobe and latched column.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            dwell_cnt <= '0;
            stab_cnt  <= '0;
            row_q     <= ROW_INIT;
            col_idx   <= '0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            stab_cnt  <= stab_nxt;
            row_q     <= row_nxt;
            col_idx   <= col_idx_nxt;
        end
    end

    // Next-state logic: step rows, qualify a press, then wait for a clean release.
    always_comb begin
        state_nxt   = state;
        dwell_nxt   = dwell_cnt;
        stab_nxt    = stab_cnt;
        row_nxt     = row_q;
        col_idx_nxt = col_idx;
        accept      = 1'b0;
        case (state)
            SCAN: begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (col_in != 4'hF) begin
                        col_idx_nxt = col_to_idx(col_in);
                        stab_nxt    = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        row_nxt = {row_q[2:0], row_q[3]};
                    end
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_in[col_idx]) begin
                    state_nxt = SCAN;
                    row_nxt   = {row_q[2:0], row_q[3]};
                    dwell_nxt = '0;
                    stab_nxt  = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    accept    = 1'b1;
                    state_nxt = HELD;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt = stab_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!col_in[col_idx]) begin
                    stab_nxt = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nxt = SCAN;
                    row_nxt   = {row_q[2:0], row_q[3]};
                    dwell_nxt = '0;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt = stab_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

`ifdef KEYPAD_FIFO_EN
    logic fifo_empty;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_key_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (new_code),
        .pop       (key_ack),
        .head      (key_code),
        .empty     (fifo_empty),
        .drop      (key_ovf)
    );

    assign key_valid = !fifo_empty;
`else
    // Single holding register: a new key replaces the old one only if it was consumed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_ovf   <= 1'b0;
        end else begin
            key_ovf <= 1'b0;
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= new_code;
                    key_valid <= 1'b1;
                end else begin
                    key_ovf <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: self-checking bench with a keypad model that
// drives columns only while the pressed key's row is strobed. Expected key
// codes go into a queue when a press is applied and are compared when the
// DUT presents them. Honours KEYPAD_FIFO_EN for the queue-capacity cases.
module tb_keypad_scan_controller;

`ifdef KEYPAD_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    localparam int NKEYS = CAP + 1;

    localparam logic [3:0] TBL_ROW  [5] = '{4'b1101, 4'b0111, 4'b1110, 4'b1011, 4'b1101};
    localparam logic [3:0] TBL_COL  [5] = '{4'b0111, 4'b1011, 4'b1110, 4'b0011, 4'b1100};
    localparam logic [3:0] TBL_CODE [5] = '{4'b0111, 4'b1110, 4'b0000, 4'b1010, 4'b0100};

    logic       clk;
    logic       rst;
    logic [3:0] col_in;
    logic       key_ack;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_ovf;

    logic       press_on;
    logic [3:0] press_row;
    logic [3:0] press_col;

    logic [3:0] expQ [$];
    int         total;
    int         bad;
    int         guard;
    logic [3:0] exp_row;

    keypad_scan_controller #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .key_ack   (key_ack),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_ovf   (key_ovf)
    );

    assign col_in = (press_on && row_out == press_row) ? press_col : 4'hF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] peekQ();
        if (expQ.size() == 0) return 4'bxxxx;
        return expQ[0];
    endfunction

    // Waits for the row to be freshly strobed, presses at its sample cycle (returns at t0).
    task automatic applyStimulus(input logic [3:0] row, input logic [3:0] cols,
                                 input logic [3:0] code, input bit keep);
        int g;
        g = 0;
        while (row_out == row && g < 40) begin
            @(negedge clk);
            g++;
        end
        while (row_out != row && g < 40) begin
            @(negedge clk);
            g++;
        end
        checkOutput("row_reached", row_out, row);
        repeat (3) @(negedge clk);
        press_row = row;
        press_col = cols;
        press_on  = 1'b1;
        if (keep) expQ.push_back(code);
    endtask

    task automatic ackKey(input string tag);
        logic [3:0] exp;
        checkOutput({tag, "_valid"}, key_valid, 1);
        if (expQ.size() > 0) exp = expQ.pop_front();
        else exp = 4'bxxxx;
        checkOutput({tag, "_code"}, key_code, exp);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic releaseKey(input string tag);
        int g;
        press_on = 1'b0;
        g = 0;
        while (key_held && g < 30) begin
            @(negedge clk);
            g++;
        end
        checkOutput({tag, "_release"}, key_held, 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        key_ack  = 1'b0;
        press_on = 1'b0;
        press_row = 4'hF;
        press_col = 4'hF;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_row", row_out, 4'b1110);
        checkOutput("rst_code", key_code, 0);
        checkOutput("rst_valid", key_valid, 0);
        checkOutput("rst_held", key_held, 0);
        checkOutput("rst_ovf", key_ovf, 0);
        rst = 1'b0;

        // Idle scan: row steps every 4 cycles and wraps after 16
        for (int k = 0; k < 20; k++) begin
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            checkOutput("t1_row", row_out, exp_row);
            checkOutput("t1_valid", key_valid, 0);
            @(negedge clk);
        end

        // Press on row 1011, column 1 -> code 1001 at t0+9
        applyStimulus(4'b1011, 4'b1101, 4'b1001, 1'b1);
        repeat (8) @(negedge clk);
        checkOutput("t2_valid_early", key_valid, 0);
        checkOutput("t2_held_early", key_held, 0);
        @(negedge clk);
        checkOutput("t2_valid", key_valid, 1);
        checkOutput("t2_code", key_code, peekQ());
        checkOutput("t2_held", key_held, 1);
        checkOutput("t2_row_frozen", row_out, 4'b1011);

        // Release starting at t0+11; held clears after 8 clean cycles
        repeat (2) @(negedge clk);
        press_on = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("t4_held_late", key_held, 1);
        checkOutput("t4_row_still", row_out, 4'b1011);
        @(negedge clk);
        checkOutput("t4_held_clear", key_held, 0);
        checkOutput("t4_row_adv", row_out, 4'b0111);
        ackKey("t4");
        checkOutput("t4_valid_drop", key_valid, 0);

        // Bounce: press abandoned at t0+4, scan resumes
        applyStimulus(4'b1011, 4'b1101, 4'b1001, 1'b0);
        repeat (4) @(negedge clk);
        press_on = 1'b0;
        checkOutput("t3_row_hold", row_out, 4'b1011);
        @(negedge clk);
        checkOutput("t3_row_adv", row_out, 4'b0111);
        checkOutput("t3_valid", key_valid, 0);
        checkOutput("t3_held", key_held, 0);
        repeat (4) @(negedge clk);
        checkOutput("t3_rescan", row_out, 4'b1110);

        // Keys accepted without ack: the one beyond capacity is dropped
        for (int i = 0; i < NKEYS; i++) begin
            applyStimulus(TBL_ROW[i], TBL_COL[i], TBL_CODE[i], (i < CAP));
            repeat (8) @(negedge clk);
            checkOutput("t5_ovf_pre", key_ovf, 0);
            @(negedge clk);
            checkOutput("t5_held", key_held, 1);
            checkOutput("t5_valid", key_valid, 1);
            checkOutput("t5_ovf", key_ovf, (i >= CAP));
            checkOutput("t5_head", key_code, peekQ());
            @(negedge clk);
            checkOutput("t5_ovf_post", key_ovf, 0);
            releaseKey("t5");
        end
        for (int i = 0; i < CAP; i++) begin
            ackKey("t5_pop");
        end
        checkOutput("t5_empty", key_valid, 0);

        // Ack with nothing pending is ignored
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        checkOutput("ack_idle_valid", key_valid, 0);

        // Reset mid-debounce with the key still down
        applyStimulus(4'b1011, 4'b1110, 4'b1000, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_row", row_out, 4'b1110);
        checkOutput("t6_valid", key_valid, 0);
        checkOutput("t6_held", key_held, 0);
        rst = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            checkOutput("t6_wait_valid", key_valid, 0);
        end
        @(negedge clk);
        ackKey("t6");
        checkOutput("t6_valid_drop", key_valid, 0);
        releaseKey("t6");
        checkOutput("t6_queue_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
